// File: rtl/intpol2_mc_stream.sv
// intpol2_mc_stream
//   Multi-channel streaming quadratic (3-point) interpolator. Samples arrive
//   time-multiplexed round-robin over N_CH channels; each channel keeps a
//   3-sample history. Once a channel holds 3 samples, every accepted sample
//   produces a burst of D = 2^L clamped points that interpolate m0 -> m1.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   clear                synchronous clear (same effect as reset)
//   log2_d               requested L, saturated to MAX_LOG2_D, latched per burst
//   min_thold, max_thold signed clamp limits
//   in_valid/in_ready    input handshake, in_data = sample for current channel
//   out_valid/out_ready  output handshake
//   out_data             interpolated, clamped sample
//   out_ch               channel of out_data
//   out_last             last point of a burst
//   out_sat              out_data was clamped
//   primed               per-channel: at least 3 samples since reset/clear
module intpol2_mc_stream #(
    parameter int DATA_W     = 32,
    parameter int GUARD      = 2,
    parameter int N_CH       = 4,
    parameter int MAX_LOG2_D = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  clear,
    input  logic [$clog2(MAX_LOG2_D+1)-1:0]       log2_d,
    input  logic [DATA_W-1:0]                     min_thold,
    input  logic [DATA_W-1:0]                     max_thold,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_W-1:0]                     in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_W-1:0]                     out_data,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch,
    output logic                                  out_last,
    output logic                                  out_sat,
    output logic [N_CH-1:0]                       primed
);

    localparam int MW  = DATA_W + GUARD;
    localparam int LW  = $clog2(MAX_LOG2_D + 1);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IW  = MAX_LOG2_D;
    // Product/sum width: coefficient * i^2 plus headroom for the final adds.
    localparam int PW  = MW + 2 * IW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COEF,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [MW-1:0] r_m0 [N_CH];
    logic signed [MW-1:0] r_m1 [N_CH];
    logic signed [MW-1:0] r_m2 [N_CH];
    logic [1:0]           r_cnt [N_CH];
    logic [CHW-1:0]       r_chp;
    logic [CHW-1:0]       r_ch;
    logic signed [MW-1:0] r_p0;
    logic signed [MW-1:0] r_p1;
    logic signed [MW-1:0] r_p2;
    logic [LW-1:0]        r_l;
    logic [IW-1:0]        r_i;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_prime;
    logic                 w_last;
    logic [IW-1:0]        w_dm1;
    logic [LW-1:0]        w_leff;
    logic signed [MW-1:0] w_din;
    logic signed [MW-1:0] w_cm0;
    logic signed [MW-1:0] w_cm1;
    logic signed [MW-1:0] w_cm2;
    logic signed [MW-1:0] w_sum;
    logic signed [MW-1:0] w_s;
    logic signed [MW-1:0] w_p1;
    logic signed [MW-1:0] w_p2;

    logic signed [PW-1:0] w_ix;
    logic signed [PW-1:0] w_isq;
    logic signed [PW-1:0] w_p0x;
    logic signed [PW-1:0] w_p1x;
    logic signed [PW-1:0] w_p2x;
    logic signed [PW-1:0] w_prod1;
    logic signed [PW-1:0] w_prod2;
    logic signed [PW-1:0] w_t1;
    logic signed [PW-1:0] w_t2;
    logic signed [PW-1:0] w_y;
    logic signed [PW-1:0] w_maxx;
    logic signed [PW-1:0] w_minx;
    logic [LW:0]          w_sh2;
    logic [DATA_W-1:0]    w_yc;
    logic                 w_sat;

    // Handshake qualifiers come straight from the state register so there is
    // no combinational path from in_valid/out_ready to in_ready/out_valid.
    assign w_in_fire  = in_valid & (r_state == S_IDLE);
    assign w_out_fire = out_ready & (r_state == S_RUN);
    assign w_prime    = (r_cnt[r_chp] >= 2'd2);
    assign w_din      = MW'($signed(in_data));
    assign w_leff     = (log2_d > LW'(MAX_LOG2_D)) ? LW'(MAX_LOG2_D) : log2_d;
    assign w_dm1      = IW'((32'd1 << r_l) - 32'd1);
    assign w_last     = (r_i == w_dm1);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_in_fire && w_prime) w_next = S_COEF;
            end
            S_COEF: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                out_valid = 1'b1;
                if (w_out_fire && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- coefficients
    // The burst channel is captured at the input fire (chp has already moved
    // on by COEF), so COEF reads the history of r_ch.
    assign w_cm0 = r_m0[r_ch];
    assign w_cm1 = r_m1[r_ch];
    assign w_cm2 = r_m2[r_ch];
    assign w_sum = w_cm2 + w_cm0;
    assign w_s   = w_sum >>> 1;
    assign w_p2  = w_s - w_cm1;
    assign w_p1  = (w_cm1 <<< 1) - w_cm0 - w_s;

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_m0[c]  <= '0;
                r_m1[c]  <= '0;
                r_m2[c]  <= '0;
                r_cnt[c] <= '0;
            end
            r_chp <= '0;
            r_ch  <= '0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_p2  <= '0;
            r_l   <= '0;
            r_i   <= '0;
        end else if (clear) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_m0[c]  <= '0;
                r_m1[c]  <= '0;
                r_m2[c]  <= '0;
                r_cnt[c] <= '0;
            end
            r_chp <= '0;
            r_ch  <= '0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_p2  <= '0;
            r_l   <= '0;
            r_i   <= '0;
        end else begin
            if (w_in_fire) begin
                r_m0[r_chp]  <= r_m1[r_chp];
                r_m1[r_chp]  <= r_m2[r_chp];
                r_m2[r_chp]  <= w_din;
                r_cnt[r_chp] <= (r_cnt[r_chp] == 2'd3) ? 2'd3 : r_cnt[r_chp] + 2'd1;
                r_chp        <= (r_chp == CHW'(N_CH - 1)) ? '0 : r_chp + CHW'(1);
                r_ch         <= r_chp;
            end
            if (r_state == S_COEF) begin
                r_l  <= w_leff;
                r_p0 <= w_cm0;
                r_p1 <= w_p1;
                r_p2 <= w_p2;
                r_i  <= '0;
            end
            if (w_out_fire) begin
                r_i <= r_i + IW'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            primed[c] = (r_cnt[c] == 2'd3);
        end
    end

    // ------------------------------------------------------------ output
    // Full-width evaluation; truncation to DATA_W only after the clamp.
    assign w_ix    = PW'(r_i);
    assign w_isq   = w_ix * w_ix;
    assign w_p0x   = PW'(r_p0);
    assign w_p1x   = PW'(r_p1);
    assign w_p2x   = PW'(r_p2);
    assign w_prod1 = w_p1x * w_ix;
    assign w_prod2 = w_p2x * w_isq;
    assign w_sh2   = {r_l, 1'b0};
    assign w_t1    = w_prod1 >>> r_l;
    assign w_t2    = w_prod2 >>> w_sh2;
    assign w_y     = w_p0x + w_t1 + w_t2;
    assign w_maxx  = PW'($signed(max_thold));
    assign w_minx  = PW'($signed(min_thold));

    always_comb begin
        w_sat = 1'b0;
        w_yc  = w_y[DATA_W-1:0];
        if (w_y > w_maxx) begin
            w_sat = 1'b1;
            w_yc  = max_thold;
        end else if (w_y < w_minx) begin
            w_sat = 1'b1;
            w_yc  = min_thold;
        end
    end

    assign out_data = (r_state == S_RUN) ? w_yc : '0;
    assign out_sat  = (r_state == S_RUN) & w_sat;
    assign out_last = (r_state == S_RUN) & w_last;
    assign out_ch   = r_ch;

endmodule
